seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display that shares one `bcd_to_7seg` decoder among all digits. It holds a double-buffered BCD display word, walks the digits in a fixed order, and drives the shared decoder's `bcd` input. It also drives the active-low anode enables, inserts an all-dark guard interval between digits against ghosting, and reports decoder-invalid digits through a sticky error flag. New display words are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: number of digits; legal range 2..8.
- `DIV`, 50000: clock cycles a digit stays lit (SHOW); minimum 2.
- `GUARD_CYCLES`, 500: all-dark cycles before each digit (GUARD); minimum 1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  1 = scanning, 0 = display dark.
- `load`  in  1  request to capture `data_in`; accepted only when `ready`=1.
- `data_in`  in  4*NUM_DIGITS  BCD word; digit i = bits [4i+3:4i], digit 0 rightmost.
- `ready`  out  1  1 = no uncommitted word pending.
- `dec_valid`  in  1  `valid` output of the shared decoder.
- `err_clr`  in  1  clears `err`.
- `bcd_out`  out  4  to the decoder `bcd` input; the current digit's nibble.
- `an`  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all-ones.
- `digit_idx`  out  clog2(NUM_DIGITS)  index of the digit being scanned.
- `frame_tick`  out  1  one-cycle pulse at each frame commit point.
- `err`  out  1  sticky: a digit was shown while `dec_valid`=0.

## Operation
- Registers: `active` word (displayed), `pending` word plus a pending flag, state, digit index, slot counter.
- States: OFF, GUARD, SHOW.
  - OFF: `an` all ones. If `enable`=1, go to GUARD with digit 0 and counter 0.
  - GUARD: `an` all ones. Stays GUARD_CYCLES cycles, then goes to SHOW with counter 0.
  - SHOW: `an[digit_idx]`=0. Stays DIV cycles. It then goes to GUARD for digit+1, or wraps to digit 0 after digit NUM_DIGITS-1.
- `enable`=0 in any state: go to OFF at the next edge. The digit index and counter reset to 0. `pending` and `active` are kept.
- `bcd_out` is registered. It equals `active[4*digit_idx+3 : 4*digit_idx]` in GUARD and SHOW, and 0 in OFF.
- Load handshake:
  - In OFF: an accepted load writes `active` directly; `ready` stays 1.
  - While scanning: an accepted load writes `pending` and drops `ready` to 0 at the next edge.
  - `load` while `ready`=0 is ignored; the earlier word is not overwritten.
- Commit: on the wrap edge (last digit SHOW to digit 0 GUARD), `pending` is copied to `active`, the flag clears, and `ready` returns to 1.
  - Load on the commit edge with no word pending: `data_in` goes straight to `active` and `ready` stays 1.
- `err` sets when the state is SHOW, the digit is actually lit, and `dec_valid`=0. It stays set until `err_clr`. `err_clr` wins over a simultaneous set.
- Counter widths are clog2 of DIV and GUARD_CYCLES. The counters never overflow; they wrap explicitly at their terminal count.

## Timing
- Reset values: `an` all ones, `bcd_out`=0, `digit_idx`=0, `ready`=1, `frame_tick`=0, `err`=0. State OFF, `active`=0, no word pending.
- Reset asserted mid-frame: all registers go to reset values immediately (asynchronous) and any pending word is discarded.
- Frame length is NUM_DIGITS*(GUARD_CYCLES+DIV) cycles.
- Enable sampled 1 at edge k: GUARD occupies cycles k..k+GUARD_CYCLES-1, and `an[0]` goes low from edge k+GUARD_CYCLES.
- `bcd_out` changes at the start of GUARD, so the decoder output is settled before the anode turns on.
- `frame_tick`=1 for exactly the first GUARD cycle of digit 0 after a wrap. It is not asserted on the initial start from OFF.
- `ready` rises in the same cycle `frame_tick` is high.

## Configuration
- Macro: `SEG7_SCAN_LZB_EN` (leading-zero blanking).
- Defined: during the SHOW slot of each digit i>0, `an` stays all ones if that digit and every higher digit of `active` are 0. Digit 0 is always lit. `err` is not set for blanked slots. Slot timing is unchanged.
- Undefined: every digit is lit in its slot regardless of value.

## Test plan
Bench parameters are NUM_DIGITS=4, DIV=4, GUARD_CYCLES=2, giving a 24-cycle frame.
- Reset, then hold `enable`=0 for 10 cycles -> `an`=4'b1111, `bcd_out`=0, `ready`=1, `err`=0 throughout.
- Load 16'h1234 in OFF, then enable -> over the next frames `an` sequence is 1111×2, 1110×4, 1111×2, 1101×4, … with `bcd_out` 4,3,2,1. `frame_tick` pulses every 24 cycles.
- While scanning with 16'h1234, load 16'h5678 mid-frame -> `ready`=0 until the wrap, `frame_tick` and `ready`=1 in the same cycle, digit 0 then shows 8. A second load 16'h9999 while `ready`=0 is ignored.
- Stub `dec_valid`=0 when `bcd_out`=4'hA, and load 16'h00A0 -> `err` sets during digit 1 SHOW. Pulse `err_clr` -> `err`=0, then it sets again on the next frame.
- With `SEG7_SCAN_LZB_EN`, load 16'h0050 -> digits 3 and 2 stay dark, digits 1 and 0 are lit showing 5 and 0. Without the macro, all four digits are lit.
- Assert `rst` during digit 2 SHOW with a word pending -> outputs take reset values immediately and the pending word is lost. After release and enable, scanning restarts at digit 0 with `active`=0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display sharing one BCD decoder.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            load,
  input  logic [4*NUM_DIGITS-1:0]         data_in,
  output logic                            ready,
  input  logic                            dec_valid,
  input  logic                            err_clr,
  output logic [3:0]                      bcd_out,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_tick,
  output logic                            err
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(DIV);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] D_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_SHOW} state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic [SW-1:0]           scnt_reg, scnt_next;
  logic [GW-1:0]           gcnt_reg, gcnt_next;
  logic [4*NUM_DIGITS-1:0] active_reg, active_next;
  logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
  logic                    pend_reg, pend_next;
  logic [3:0]              bcd_reg, bcd_next;
  logic                    tick_reg, err_reg;
  logic                    wrap, accept, lit;
  logic [NUM_DIGITS-1:0]   an_c;
  logic [NUM_DIGITS-1:0]   blank_vec;

`ifdef SEG7_SCAN_LZB_EN
  // upper_zero[i]: digit i and every digit above it are zero
  logic [NUM_DIGITS:1] upper_zero;
  assign upper_zero[NUM_DIGITS] = 1'b1;
  assign blank_vec[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
    assign upper_zero[gi] = upper_zero[gi+1] && (active_reg[4*gi +: 4] == 4'h0);
    assign blank_vec[gi]  = upper_zero[gi];
  end
`else
  assign blank_vec = '0;
`endif

  // State register with scan position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_OFF;
      idx_reg   <= '0;
      scnt_reg  <= '0;
      gcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      scnt_reg  <= scnt_next;
      gcnt_reg  <= gcnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    scnt_next  = scnt_reg;
    gcnt_next  = gcnt_reg;
    wrap       = 1'b0;
    if (!enable) begin
      state_next = ST_OFF;
      idx_next   = '0;
      scnt_next  = '0;
      gcnt_next  = '0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_next = ST_GUARD;
          idx_next   = '0;
          scnt_next  = '0;
          gcnt_next  = '0;
        end
        ST_GUARD: begin
          if (gcnt_reg == G_LAST) begin
            state_next = ST_SHOW;
            gcnt_next  = '0;
            scnt_next  = '0;
          end else begin
            gcnt_next = gcnt_reg + 1'b1;
          end
        end
        ST_SHOW: begin
          if (scnt_reg == S_LAST) begin
            state_next = ST_GUARD;
            scnt_next  = '0;
            gcnt_next  = '0;
            if (idx_reg == D_LAST) begin
              idx_next = '0;
              wrap     = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end else begin
            scnt_next = scnt_reg + 1'b1;
          end
        end
        default: state_next = ST_OFF;
      endcase
    end
  end

  // Output logic: one anode low while the current digit is shown and not blanked
  always_comb begin
    an_c = '1;
    lit  = 1'b0;
    if (state_reg == ST_SHOW && !blank_vec[idx_reg]) begin
      lit           = 1'b1;
      an_c[idx_reg] = 1'b0;
    end
  end

  // Display word buffering; a pending word moves to active only at the wrap edge
  always_comb begin
    active_next  = active_reg;
    pending_next = pending_reg;
    pend_next    = pend_reg;
    accept       = load && !pend_reg;
    if (wrap && pend_reg) begin
      active_next = pending_reg;
      pend_next   = 1'b0;
    end else if (accept && (state_reg == ST_OFF || wrap)) begin
      active_next = data_in;
    end else if (accept) begin
      pending_next = data_in;
      pend_next    = 1'b1;
    end
    // bcd_out follows the upcoming digit so the decoder settles during GUARD
    bcd_next = (state_next == ST_OFF) ? 4'h0 : active_next[{idx_next, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_reg  <= '0;
      pending_reg <= '0;
      pend_reg    <= 1'b0;
      bcd_reg     <= 4'h0;
      tick_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      active_reg  <= active_next;
      pending_reg <= pending_next;
      pend_reg    <= pend_next;
      bcd_reg     <= bcd_next;
      tick_reg    <= wrap;
      if (err_clr)
        err_reg <= 1'b0;
      else if (state_reg == ST_SHOW && lit && !dec_valid)
        err_reg <= 1'b1;
    end
  end

  assign ready      = !pend_reg;
  assign bcd_out    = bcd_reg;
  assign an         = an_c;
  assign digit_idx  = idx_reg;
  assign frame_tick = tick_reg;
  assign err        = err_reg;

endmodule
